// File: rtl/pipe_hazard_sched.sv
// Pipeline hazard scheduler for a 5-stage in-order pipeline.
// Detects load-use hazards, applies taken-branch flushes, freezes the back end while the
// data memory is busy (with a timeout), and sequences a halt by draining the pipeline.
//
// Ports:
//   clk, rst                 clock and synchronous active-high reset
//   id_rs, id_rt, id_uses_rt source registers of the IF/ID instruction
//   ex_memread, ex_rt        load flag and destination of the ID/EX instruction
//   mem_pcsrc                taken branch resolved in EX/MEM
//   mem_access, dmem_ready   EX/MEM memory access and data-memory done handshake
//   halt_req                 halt instruction decoded in IF/ID
//   pc_write, if_id_write    PC and IF/ID load enables
//   id_ex_bubble             zero the ID/EX control fields
//   if_id_flush, id_ex_flush, ex_mem_flush   clear the named pipeline register
//   freeze                   hold ID/EX, EX/MEM and MEM/WB
//   state                    RUN=0, WAIT=1, DRAIN=2, HALTED=3
//   halted, err              halt reached; sticky memory timeout
//   stall_cnt, flush_cnt     saturating performance counters
module pipe_hazard_sched #(
    parameter int unsigned TIMEOUT = 16,
    parameter int unsigned CNT_W   = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       id_rs,
    input  logic [4:0]       id_rt,
    input  logic             id_uses_rt,
    input  logic             ex_memread,
    input  logic [4:0]       ex_rt,
    input  logic             mem_pcsrc,
    input  logic             mem_access,
    input  logic             dmem_ready,
    input  logic             halt_req,
    output logic             pc_write,
    output logic             if_id_write,
    output logic             id_ex_bubble,
    output logic             if_id_flush,
    output logic             id_ex_flush,
    output logic             ex_mem_flush,
    output logic             freeze,
    output logic [1:0]       state,
    output logic             halted,
    output logic             err,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    localparam int unsigned    WaitW     = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [WaitW-1:0] WaitLast  = WaitW'(TIMEOUT - 1);
    localparam logic [1:0]     DrainLast = 2'd3;

    typedef enum logic [1:0] {
        StRun    = 2'd0,
        StWait   = 2'd1,
        StDrain  = 2'd2,
        StHalted = 2'd3
    } state_e;

    state_e             state_q, state_d;
    logic [WaitW-1:0]   wait_cnt_q, wait_cnt_d;
    logic [1:0]         drain_cnt_q, drain_cnt_d;
    logic               err_q, err_d;
    logic [CNT_W-1:0]   stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0]   flush_cnt_q, flush_cnt_d;
    logic               stall_inc, flush_inc;
    logic               lu_hazard, mwait;

    // r0 is hardwired zero, so a load targeting it never creates a dependency.
    assign lu_hazard = ex_memread & (ex_rt != 5'd0) &
                       ((ex_rt == id_rs) | (id_uses_rt & (ex_rt == id_rt)));
    assign mwait     = mem_access & ~dmem_ready;

    always_comb begin
        pc_write     = 1'b0;
        if_id_write  = 1'b0;
        id_ex_bubble = 1'b0;
        if_id_flush  = 1'b0;
        id_ex_flush  = 1'b0;
        ex_mem_flush = 1'b0;
        freeze       = 1'b0;
        state_d      = state_q;
        wait_cnt_d   = wait_cnt_q;
        drain_cnt_d  = drain_cnt_q;
        err_d        = err_q;
        stall_inc    = 1'b0;
        flush_inc    = 1'b0;

        if (rst) begin
            freeze       = 1'b1;
            if_id_flush  = 1'b1;
            id_ex_flush  = 1'b1;
            ex_mem_flush = 1'b1;
            state_d      = StRun;
            wait_cnt_d   = '0;
            drain_cnt_d  = '0;
            err_d        = 1'b0;
        end else begin
            unique case (state_q)
                StRun, StWait: begin
                    if (mwait) begin
                        // A pending branch stays asserted in the frozen EX/MEM and is
                        // taken once the freeze releases.
                        freeze    = 1'b1;
                        stall_inc = 1'b1;
                        if (wait_cnt_q == WaitLast) begin
                            err_d      = 1'b1;
                            state_d    = StHalted;
                            wait_cnt_d = '0;
                        end else begin
                            wait_cnt_d = wait_cnt_q + WaitW'(1);
                            state_d    = StWait;
                        end
                    end else begin
                        wait_cnt_d = '0;
                        state_d    = StRun;
                        if (mem_pcsrc) begin
                            // Squashes the younger instructions, so hazards/halts are moot.
                            pc_write     = 1'b1;
                            if_id_write  = 1'b1;
                            if_id_flush  = 1'b1;
                            id_ex_flush  = 1'b1;
                            ex_mem_flush = 1'b1;
                            flush_inc    = 1'b1;
                        end else if (halt_req) begin
                            if_id_write = 1'b1;
                            if_id_flush = 1'b1;
                            state_d     = StDrain;
                            drain_cnt_d = '0;
                        end else if (lu_hazard) begin
                            id_ex_bubble = 1'b1;
                            stall_inc    = 1'b1;
                        end else begin
                            pc_write    = 1'b1;
                            if_id_write = 1'b1;
                        end
                    end
                end
                StDrain: begin
                    if_id_write = 1'b1;
                    if_id_flush = 1'b1;
                    freeze      = mwait;
                    if (!mwait) begin
                        if (mem_pcsrc) begin
                            id_ex_flush  = 1'b1;
                            ex_mem_flush = 1'b1;
                        end
                        if (drain_cnt_q == DrainLast) begin
                            state_d = StHalted;
                        end else begin
                            drain_cnt_d = drain_cnt_q + 2'd1;
                        end
                    end
                end
                StHalted: begin
                    freeze = 1'b1;
                end
                default: begin
                    state_d = StRun;
                end
            endcase
        end
    end

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (stall_inc && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end
        if (flush_inc && (flush_cnt_q != '1)) begin
            flush_cnt_d = flush_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StRun;
            wait_cnt_q  <= '0;
            drain_cnt_q <= '0;
            err_q       <= 1'b0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            wait_cnt_q  <= wait_cnt_d;
            drain_cnt_q <= drain_cnt_d;
            err_q       <= err_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign state     = state_q;
    assign halted    = (state_q == StHalted);
    assign err       = err_q;
    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;

endmodule

// File: tb/tb_pipe_hazard_sched.sv
// Self-checking bench for pipe_hazard_sched: directed scenarios followed by randomized
// stimulus, all outputs compared every cycle against a behavioural reference model.
module tb_pipe_hazard_sched;

    localparam int unsigned TIMEOUT = 16;
    localparam int unsigned CNT_W   = 5;
    localparam int          CNT_MAX = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             rst;
    logic [4:0]       id_rs, id_rt, ex_rt;
    logic             id_uses_rt, ex_memread, mem_pcsrc, mem_access, dmem_ready, halt_req;
    logic             pc_write, if_id_write, id_ex_bubble;
    logic             if_id_flush, id_ex_flush, ex_mem_flush, freeze;
    logic [1:0]       state;
    logic             halted, err;
    logic [CNT_W-1:0] stall_cnt, flush_cnt;

    pipe_hazard_sched #(
        .TIMEOUT (TIMEOUT),
        .CNT_W   (CNT_W)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .id_rs        (id_rs),
        .id_rt        (id_rt),
        .id_uses_rt   (id_uses_rt),
        .ex_memread   (ex_memread),
        .ex_rt        (ex_rt),
        .mem_pcsrc    (mem_pcsrc),
        .mem_access   (mem_access),
        .dmem_ready   (dmem_ready),
        .halt_req     (halt_req),
        .pc_write     (pc_write),
        .if_id_write  (if_id_write),
        .id_ex_bubble (id_ex_bubble),
        .if_id_flush  (if_id_flush),
        .id_ex_flush  (id_ex_flush),
        .ex_mem_flush (ex_mem_flush),
        .freeze       (freeze),
        .state        (state),
        .halted       (halted),
        .err          (err),
        .stall_cnt    (stall_cnt),
        .flush_cnt    (flush_cnt)
    );

    initial forever #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: 0 run, 1 waiting on memory, 2 draining, 3 halted.
    int m_state, m_wait, m_drain, m_err, m_stall, m_flush;
    int n_state, n_wait, n_drain, n_err, n_stall, n_flush;
    int e_pc, e_ifw, e_bub, e_ifl, e_idfl, e_exfl, e_frz;
    int stuck_left = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int sat_inc(input int v);
        return (v >= CNT_MAX) ? CNT_MAX : v + 1;
    endfunction

    task automatic model_eval();
        int lu;
        int mw;
        lu = (ex_memread && ex_rt != 5'd0 &&
              (ex_rt == id_rs || (id_uses_rt && ex_rt == id_rt))) ? 1 : 0;
        mw = (mem_access && !dmem_ready) ? 1 : 0;
        e_pc = 0; e_ifw = 0; e_bub = 0; e_ifl = 0; e_idfl = 0; e_exfl = 0; e_frz = 0;
        n_state = m_state; n_wait = m_wait; n_drain = m_drain;
        n_err = m_err; n_stall = m_stall; n_flush = m_flush;
        if (rst) begin
            e_frz = 1; e_ifl = 1; e_idfl = 1; e_exfl = 1;
            n_state = 0; n_wait = 0; n_drain = 0; n_err = 0; n_stall = 0; n_flush = 0;
        end else if (m_state == 0 || m_state == 1) begin
            if (mw == 1) begin
                e_frz   = 1;
                n_stall = sat_inc(m_stall);
                n_wait  = m_wait + 1;
                if (n_wait >= TIMEOUT) begin
                    n_err = 1; n_state = 3; n_wait = 0;
                end else begin
                    n_state = 1;
                end
            end else begin
                n_wait  = 0;
                n_state = 0;
                if (mem_pcsrc) begin
                    e_pc = 1; e_ifw = 1; e_ifl = 1; e_idfl = 1; e_exfl = 1;
                    n_flush = sat_inc(m_flush);
                end else if (halt_req) begin
                    e_ifw = 1; e_ifl = 1; n_state = 2; n_drain = 0;
                end else if (lu == 1) begin
                    e_bub = 1; n_stall = sat_inc(m_stall);
                end else begin
                    e_pc = 1; e_ifw = 1;
                end
            end
        end else if (m_state == 2) begin
            e_ifw = 1; e_ifl = 1; e_frz = mw;
            if (mw == 0) begin
                if (mem_pcsrc) begin
                    e_idfl = 1; e_exfl = 1;
                end
                n_drain = m_drain + 1;
                if (n_drain == 4) n_state = 3;
            end
        end else begin
            e_frz = 1;
        end
    endtask

    task automatic compare_all();
        check_eq("pc_write", 32'(pc_write), e_pc);
        check_eq("if_id_write", 32'(if_id_write), e_ifw);
        check_eq("id_ex_bubble", 32'(id_ex_bubble), e_bub);
        check_eq("if_id_flush", 32'(if_id_flush), e_ifl);
        check_eq("id_ex_flush", 32'(id_ex_flush), e_idfl);
        check_eq("ex_mem_flush", 32'(ex_mem_flush), e_exfl);
        check_eq("freeze", 32'(freeze), e_frz);
        check_eq("state", 32'(state), m_state);
        check_eq("halted", 32'(halted), (m_state == 3) ? 1 : 0);
        check_eq("err", 32'(err), m_err);
        check_eq("stall_cnt", 32'(stall_cnt), m_stall);
        check_eq("flush_cnt", 32'(flush_cnt), m_flush);
    endtask

    // Called just after a rising edge with inputs already applied.
    task automatic step();
        #4;
        model_eval();
        compare_all();
        @(posedge clk);
        m_state = n_state; m_wait = n_wait; m_drain = n_drain;
        m_err = n_err; m_stall = n_stall; m_flush = n_flush;
        #1;
    endtask

    task automatic set_idle();
        rst = 1'b0; id_rs = 5'd0; id_rt = 5'd0; id_uses_rt = 1'b0; ex_memread = 1'b0;
        ex_rt = 5'd0; mem_pcsrc = 1'b0; mem_access = 1'b0; dmem_ready = 1'b1;
        halt_req = 1'b0;
    endtask

    task automatic do_reset();
        set_idle();
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    task automatic rand_inputs();
        if (m_state == 3) rst = ($urandom_range(0, 3) == 0);
        else              rst = ($urandom_range(0, 199) == 0);
        id_rs      = 5'($urandom_range(0, 3));
        id_rt      = 5'($urandom_range(0, 3));
        id_uses_rt = ($urandom_range(0, 1) == 0);
        ex_memread = ($urandom_range(0, 2) == 0);
        ex_rt      = 5'($urandom_range(0, 3));
        mem_pcsrc  = ($urandom_range(0, 7) == 0);
        halt_req   = ($urandom_range(0, 31) == 0);
        if (stuck_left == 0 && $urandom_range(0, 299) == 0) stuck_left = 20;
        if (stuck_left > 0) begin
            mem_access = 1'b1;
            dmem_ready = 1'b0;
            stuck_left--;
        end else begin
            mem_access = ($urandom_range(0, 3) == 0);
            dmem_ready = ($urandom_range(0, 2) != 0);
        end
    endtask

    initial begin
        set_idle();
        rst = 1'b1;
        m_state = 0; m_wait = 0; m_drain = 0; m_err = 0; m_stall = 0; m_flush = 0;
        @(posedge clk);
        #1;
        do_reset();
        check_eq("reset_state", 32'(state), 0);
        check_eq("reset_err", 32'(err), 0);
        check_eq("reset_stall", 32'(stall_cnt), 0);

        // Load-use stall on rs.
        ex_memread = 1'b1; ex_rt = 5'd8; id_rs = 5'd8;
        #1;
        check_eq("lu_pc_write", 32'(pc_write), 0);
        check_eq("lu_bubble", 32'(id_ex_bubble), 1);
        step();
        set_idle();
        check_eq("lu_stall_cnt", 32'(stall_cnt), 1);
        check_eq("lu_state", 32'(state), 0);

        // Load into r0 is not a hazard.
        ex_memread = 1'b1; ex_rt = 5'd0; id_rs = 5'd0;
        #1;
        check_eq("r0_pc_write", 32'(pc_write), 1);
        step();

        // Branch flush wins over a simultaneous load-use hazard.
        do_reset();
        ex_memread = 1'b1; ex_rt = 5'd8; id_rs = 5'd8; mem_pcsrc = 1'b1;
        #1;
        check_eq("br_ex_mem_flush", 32'(ex_mem_flush), 1);
        check_eq("br_pc_write", 32'(pc_write), 1);
        check_eq("br_bubble", 32'(id_ex_bubble), 0);
        step();
        set_idle();
        check_eq("br_flush_cnt", 32'(flush_cnt), 1);

        // Memory wait with a deferred branch.
        do_reset();
        mem_access = 1'b1; dmem_ready = 1'b0; mem_pcsrc = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            check_eq("mw_freeze", 32'(freeze), 1);
            step();
        end
        dmem_ready = 1'b1;
        #1;
        check_eq("mw_rdy_if_id_flush", 32'(if_id_flush), 1);
        check_eq("mw_rdy_state", 32'(state), 1);
        step();
        set_idle();
        check_eq("mw_end_state", 32'(state), 0);
        check_eq("mw_stall_cnt", 32'(stall_cnt), 3);
        check_eq("mw_flush_cnt", 32'(flush_cnt), 1);

        // Timeout after 16 wait cycles, then recovery by reset.
        do_reset();
        mem_access = 1'b1; dmem_ready = 1'b0;
        repeat (15) step();
        check_eq("to_before_state", 32'(state), 1);
        check_eq("to_before_err", 32'(err), 0);
        step();
        check_eq("to_state", 32'(state), 3);
        check_eq("to_err", 32'(err), 1);
        do_reset();
        check_eq("to_rst_state", 32'(state), 0);
        check_eq("to_rst_err", 32'(err), 0);

        // Halt: four drain cycles, then halted with frozen counters.
        halt_req = 1'b1;
        step();
        halt_req = 1'b0;
        for (int i = 0; i < 4; i++) begin
            check_eq("drain_state", 32'(state), 2);
            step();
        end
        check_eq("halt_state", 32'(state), 3);
        check_eq("halt_halted", 32'(halted), 1);
        ex_memread = 1'b1; ex_rt = 5'd3; id_rs = 5'd3; mem_pcsrc = 1'b1;
        #1;
        check_eq("halt_pc_write", 32'(pc_write), 0);
        repeat (5) step();
        check_eq("halt_stall_cnt", 32'(stall_cnt), 0);
        check_eq("halt_flush_cnt", 32'(flush_cnt), 0);

        // Counter saturation.
        do_reset();
        ex_memread = 1'b1; ex_rt = 5'd5; id_rt = 5'd5; id_uses_rt = 1'b1;
        repeat (CNT_MAX + 8) step();
        check_eq("sat_stall_cnt", 32'(stall_cnt), CNT_MAX);
        set_idle();
        mem_pcsrc = 1'b1;
        repeat (CNT_MAX + 8) step();
        check_eq("sat_flush_cnt", 32'(flush_cnt), CNT_MAX);

        // Randomized traffic against the model.
        do_reset();
        repeat (4000) begin
            rand_inputs();
            step();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/pipe_hazard_sched.md
PIPE_HAZARD_SCHED -- requirements
Module: pipe_hazard_sched

Interface
REQ-001 The block SHALL use one clock and a synchronous, active-high reset; all state SHALL update on the rising edge of clk.
REQ-002 TIMEOUT, default 16, SHALL set the maximum number of data-memory wait cycles before error.
REQ-003 CNT_W, default 16, SHALL set the width of the performance counters.
REQ-004 clk  in  1  system clock.
REQ-005 rst  in  1  synchronous active-high reset.
REQ-006 id_rs, id_rt  in  5 each  source registers of the instruction in IF/ID.
REQ-007 id_uses_rt  in  1  the IF/ID instruction reads rt.
REQ-008 ex_memread, ex_rt  in  1, 5  load flag and destination of the instruction in ID/EX.
REQ-009 mem_pcsrc  in  1  taken branch resolved in EX/MEM (EX_MEM_PCSrc).
REQ-010 mem_access, dmem_ready  in  1 each  memread|memwrite in EX/MEM; data-memory done handshake.
REQ-011 halt_req  in  1  halt instruction decoded in IF/ID.
REQ-012 pc_write, if_id_write  out  1 each  PC and IF/ID load enables.
REQ-013 id_ex_bubble  out  1  zero ID/EX control fields (wb/m/ex ctl).
REQ-014 if_id_flush, id_ex_flush, ex_mem_flush  out  1 each  clear the named pipeline register.
REQ-015 freeze  out  1  hold ID/EX, EX/MEM and MEM/WB.
REQ-016 state  out  2  RUN=0, WAIT=1, DRAIN=2, HALTED=3.
REQ-017 halted, err  out  1 each  halt reached; memory timeout (sticky).
REQ-018 stall_cnt, flush_cnt  out  CNT_W each  performance counters.

Function
REQ-019 lu_hazard SHALL be ex_memread & (ex_rt!=0) & ((ex_rt==id_rs) | (id_uses_rt & ex_rt==id_rt)), evaluated combinationally.
REQ-020 mwait SHALL be mem_access & ~dmem_ready.
REQ-021 All control outputs SHALL be combinational from state and the current-cycle inputs (zero-cycle latency); state and the counters SHALL be registered.
REQ-022 Priority within RUN and WAIT SHALL be: mwait > mem_pcsrc > halt_req > lu_hazard.
REQ-023 When mwait=1 in RUN or WAIT:
- freeze=1, pc_write=0, if_id_write=0, and all flushes and the bubble deasserted.
- The next state SHALL be WAIT.
- A simultaneous mem_pcsrc SHALL be deferred until the freeze releases.
REQ-024 When mem_pcsrc=1 and mwait=0:
- if_id_flush, id_ex_flush and ex_mem_flush SHALL all be 1 for exactly that cycle.
- pc_write=1 (the PC loads the branch target).
- flush_cnt SHALL increment.
REQ-025 A simultaneous lu_hazard or halt_req during a branch flush SHALL be ignored, because the flushed instruction is squashed.
REQ-026 When halt_req=1 with no higher-priority event:
- pc_write=0 and if_id_flush=1.
- The next state SHALL be DRAIN, with drain_cnt cleared to 0.
REQ-027 When lu_hazard is the only event: pc_write=0, if_id_write=0, id_ex_bubble=1 for one cycle; the state SHALL remain unchanged.
REQ-028 With no event: pc_write=1, if_id_write=1, and all other control outputs 0.
REQ-029 WAIT state:
- An internal wait_cnt SHALL increment each cycle mwait=1.
- When dmem_ready=1, outputs SHALL follow REQ-024..REQ-028 that cycle, the next state SHALL be RUN, and wait_cnt SHALL clear.
- If mwait=1 while wait_cnt==TIMEOUT-1, err SHALL set and the next state SHALL be HALTED.
REQ-030 DRAIN state:
- pc_write=0, if_id_write=1, if_id_flush=1 (nops enter); freeze follows mwait.
- drain_cnt SHALL increment on each non-frozen cycle.
- After 4 non-frozen cycles the next state SHALL be HALTED.
- mem_pcsrc in DRAIN SHALL flush ID/EX and EX/MEM only, keep pc_write=0, and not increment flush_cnt.
REQ-031 HALTED state: pc_write=0, if_id_write=0, freeze=1, halted=1; only rst SHALL exit this state.
REQ-032 stall_cnt SHALL increment on each cycle in RUN or WAIT with pc_write=0, excluding halt-entry cycles.
REQ-033 Both counters SHALL saturate at all-ones and never wrap.

Reset
REQ-034 While rst=1:
- Next state SHALL be RUN; stall_cnt, flush_cnt, wait_cnt, drain_cnt, err and halted SHALL be 0.
- Outputs during the reset cycle SHALL be pc_write=0, if_id_write=0, freeze=1, flushes=1.
REQ-035 Reset asserted in WAIT, DRAIN or HALTED SHALL return the block to RUN on the next edge, with no residual freeze or error.

Verification
REQ-036 Load-use: ex_memread=1, ex_rt=8, id_rs=8 -> one cycle with pc_write=0, if_id_write=0, id_ex_bubble=1; stall_cnt 0->1; state stays 0.
REQ-037 Zero-register load: ex_rt=0, id_rs=0, ex_memread=1 -> no stall; pc_write=1.
REQ-038 Branch with hazard: mem_pcsrc=1 and lu_hazard=1 together -> all three flushes=1, pc_write=1, bubble=0; flush_cnt 0->1.
REQ-039 Memory wait: mem_access=1, dmem_ready=0 for 3 cycles, mem_pcsrc=1 throughout -> freeze=1 and state=1 for 3 cycles; on the ready cycle, flushes=1 and state returns to 0; stall_cnt=3.
REQ-040 Timeout: dmem_ready held 0 with TIMEOUT=16 -> err=1 and state=3 after 16 wait cycles; rst for one cycle -> state=0, err=0.
REQ-041 Halt: halt_req=1 for one cycle -> state 2 for 4 cycles, then state 3, halted=1, pc_write=0, both counters frozen.
